// File: rtl/rtc_pkg.sv
// Shared widths, limits, field offsets and mode encodings for the time-of-day counter.
// Also provides the load_time range check.
package rtc_pkg;

    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned SEC_W    = 6;
    localparam int unsigned TIME_W   = 17;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned HOUR_LSB = 12;
    localparam int unsigned MIN_LSB  = 6;
    localparam int unsigned SEC_LSB  = 0;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    function automatic logic time_valid(input logic [TIME_W-1:0] t);
        return (t[HOUR_LSB +: HOUR_W] <= HOUR_W'(HOUR_MAX)) &&
               (t[MIN_LSB  +: MIN_W]  <= MIN_W'(MIN_MAX))   &&
               (t[SEC_LSB  +: SEC_W]  <= SEC_W'(SEC_MAX));
    endfunction

endpackage

// File: rtl/rtc_time_counter_if.sv
// Key/load inputs and time/mode outputs of the time-of-day counter.
// master drives keys and preload; slave is the counter itself.
interface rtc_time_counter_if;

    logic                      key_mode;
    logic                      key_inc;
    logic                      load;
    logic [rtc_pkg::TIME_W-1:0] load_time;
    logic [rtc_pkg::TIME_W-1:0] time_out;
    logic                      sec_tick;
    logic [1:0]                mode;

    modport master (
        output key_mode, key_inc, load, load_time,
        input  time_out, sec_tick, mode
    );

    modport slave (
        input  key_mode, key_inc, load, load_time,
        output time_out, sec_tick, mode
    );

endinterface

// File: rtl/rtc_time_counter_wrap_counter.sv
// Modulo-(MAX+1) field counter with preload and clear; carry flags the MAX->0 step.
// Priority: load > clr > inc.
module wrap_counter #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] MAX_Q = W'(MAX);

    assign carry = inc && (q == MAX_Q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= ld_val;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == MAX_Q) ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/rtc_time_counter.sv
// 24 h hh:mm:ss counter: prescaler to a 1 s tick, RUN/SET_HOUR/SET_MIN key FSM, preload.
// Priority per cycle: load > key_mode > key_inc > prescaler tick.
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    rtc_time_counter_if.slave   bus
);

    localparam logic [31:0] CNT_MAX = 32'(CLK_FREQ - 1);

    mode_e             state;
    logic [31:0]       cnt;
    logic              sec_tick_q;
    logic [HOUR_W-1:0] hour_q;
    logic [MIN_W-1:0]  min_q;
    logic [SEC_W-1:0]  sec_q;

    logic do_load, do_mode, do_inc, run_tick;
    logic sec_clr, min_key, hour_key;
    logic sec_carry, min_carry, hour_carry;
    logic min_inc, hour_inc;

    // An out-of-range preload is dropped entirely, so the remaining inputs act as if load were low.
    assign do_load  = bus.load && time_valid(bus.load_time);
    assign do_mode  = !do_load && bus.key_mode;
    assign do_inc   = !do_load && !bus.key_mode && bus.key_inc;
    assign run_tick = !do_load && !bus.key_mode && (state == MODE_RUN) && (cnt == CNT_MAX);

    assign sec_clr  = do_mode && (state == MODE_SET_MIN);
    assign min_key  = do_inc  && (state == MODE_SET_MIN);
    assign hour_key = do_inc  && (state == MODE_SET_HOUR);

    // Manual minute setting must not carry into the hour, so the hour only sees a minute carry
    // that was itself caused by a seconds carry.
    assign min_inc  = sec_carry || min_key;
    assign hour_inc = (sec_carry && min_carry) || hour_key;

    wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (run_tick),
        .clr    (sec_clr),
        .load   (do_load),
        .ld_val (bus.load_time[SEC_LSB +: SEC_W]),
        .q      (sec_q),
        .carry  (sec_carry)
    );

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (min_inc),
        .clr    (1'b0),
        .load   (do_load),
        .ld_val (bus.load_time[MIN_LSB +: MIN_W]),
        .q      (min_q),
        .carry  (min_carry)
    );

    wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (hour_inc),
        .clr    (1'b0),
        .load   (do_load),
        .ld_val (bus.load_time[HOUR_LSB +: HOUR_W]),
        .q      (hour_q),
        .carry  (hour_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MODE_RUN;
            cnt        <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= run_tick;
            if (do_load) begin
                state <= MODE_RUN;
                cnt   <= '0;
            end else if (do_mode) begin
                cnt <= '0;
                case (state)
                    MODE_RUN:      state <= MODE_SET_HOUR;
                    MODE_SET_HOUR: state <= MODE_SET_MIN;
                    default:       state <= MODE_RUN;
                endcase
            end else if (state == MODE_RUN) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 32'd1;
            end
        end
    end

    // Hours wrap only at midnight rollover or from the hour key.
    a_hour_wrap_src: assert property (@(posedge clk) disable iff (!rst_n)
        hour_carry |-> (hour_key || (sec_carry && min_carry)));

    assign bus.time_out = {hour_q, min_q, sec_q};
    assign bus.sec_tick = sec_tick_q;
    assign bus.mode     = state;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter with CLK_FREQ=10: expected snapshots and expected
// sec_tick times are queued by the driver and checked by an independent negedge monitor.
module tb_rtc_time_counter;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;

    typedef struct {
        int unsigned cyc;
        logic [16:0] t;
        logic [1:0]  m;
        logic        tk;
    } snap_t;

    snap_t       snap_q[$];
    logic [16:0] tick_q[$];

    rtc_time_counter_if bus();

    rtc_time_counter #(.CLK_FREQ(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    // Monitor: every sec_tick consumes one predicted time; snapshots are compared in their cycle.
    always @(negedge clk) begin
        if (bus.sec_tick === 1'b1) begin
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected cyc=%0d time_out=%h", cyc, bus.time_out);
            end else begin
                logic [16:0] e;
                e = tick_q.pop_front();
                if (bus.time_out !== e) begin
                    errors++;
                    $display("FAIL tick_time cyc=%0d got=%h exp=%h", cyc, bus.time_out, e);
                end
            end
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            snap_t s;
            s = snap_q.pop_front();
            checks++;
            if (bus.time_out !== s.t || bus.mode !== s.m || bus.sec_tick !== s.tk) begin
                errors++;
                $display("FAIL snapshot cyc=%0d got time=%h mode=%b tick=%b exp time=%h mode=%b tick=%b",
                         cyc, bus.time_out, bus.mode, bus.sec_tick, s.t, s.m, s.tk);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic snap(input logic [16:0] t, input logic [1:0] m, input logic tk);
        snap_t s;
        s.cyc = cyc;
        s.t   = t;
        s.m   = m;
        s.tk  = tk;
        snap_q.push_back(s);
    endtask

    task automatic load_pulse(input logic [16:0] v);
        bus.load      = 1'b1;
        bus.load_time = v;
        step();
        bus.load      = 1'b0;
        bus.load_time = '0;
    endtask

    task automatic mode_pulse();
        bus.key_mode = 1'b1;
        step();
        bus.key_mode = 1'b0;
    endtask

    task automatic inc_pulse();
        bus.key_inc = 1'b1;
        step();
        bus.key_inc = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.key_mode  = 1'b0;
        bus.key_inc   = 1'b0;
        bus.load      = 1'b0;
        bus.load_time = '0;
        run_n(3);
        snap(17'h0, 2'b00, 1'b0);
        rst_n = 1'b1;

        // 1: first tick exactly CLK_FREQ cycles after reset release
        tick_q.push_back(17'h00001);
        run_n(9);
        snap(17'h00000, 2'b00, 1'b0);
        step();
        snap(17'h00001, 2'b00, 1'b1);
        step();
        snap(17'h00001, 2'b00, 1'b0);

        // 2: preload then one second
        load_pulse(17'h0C8B8);
        snap(17'h0C8B8, 2'b00, 1'b0);
        tick_q.push_back(17'h0C8B9);
        run_n(9);
        snap(17'h0C8B8, 2'b00, 1'b0);
        step();
        snap(17'h0C8B9, 2'b00, 1'b1);

        // 3: midnight rollover in one step
        load_pulse(hms(23, 59, 59));
        tick_q.push_back(17'h00000);
        run_n(9);
        snap(hms(23, 59, 59), 2'b00, 1'b0);
        step();
        snap(17'h00000, 2'b00, 1'b1);

        // 4: set hour (wraps 23->0) and minute, exit clears seconds and restarts the second
        load_pulse(hms(22, 10, 30));
        mode_pulse();
        snap(hms(22, 10, 30), 2'b01, 1'b0);
        inc_pulse();
        inc_pulse();
        snap(hms(0, 10, 30), 2'b01, 1'b0);
        inc_pulse();
        snap(hms(1, 10, 30), 2'b01, 1'b0);
        mode_pulse();
        snap(hms(1, 10, 30), 2'b10, 1'b0);
        run_n(12);
        snap(hms(1, 10, 30), 2'b10, 1'b0);
        inc_pulse();
        snap(hms(1, 11, 30), 2'b10, 1'b0);
        mode_pulse();
        snap(hms(1, 11, 0), 2'b00, 1'b0);
        tick_q.push_back(hms(1, 11, 1));
        run_n(9);
        snap(hms(1, 11, 0), 2'b00, 1'b0);
        step();
        snap(hms(1, 11, 1), 2'b00, 1'b1);

        // 4b: minute wrap while setting does not carry into the hour
        load_pulse(hms(5, 59, 0));
        mode_pulse();
        mode_pulse();
        inc_pulse();
        snap(hms(5, 0, 0), 2'b10, 1'b0);
        mode_pulse();
        snap(hms(5, 0, 0), 2'b00, 1'b0);

        // 5: invalid preloads ignored; key_mode beats key_inc
        load_pulse(hms(10, 60, 0));
        snap(hms(5, 0, 0), 2'b00, 1'b0);
        load_pulse(hms(24, 0, 0));
        snap(hms(5, 0, 0), 2'b00, 1'b0);
        bus.key_mode = 1'b1;
        bus.key_inc  = 1'b1;
        step();
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
        snap(hms(5, 0, 0), 2'b01, 1'b0);

        // 5b: load from SET_HOUR returns to RUN; load beats a coincident tick
        load_pulse(hms(8, 0, 0));
        snap(hms(8, 0, 0), 2'b00, 1'b0);
        run_n(9);
        snap(hms(8, 0, 0), 2'b00, 1'b0);
        load_pulse(hms(9, 9, 9));
        snap(hms(9, 9, 9), 2'b00, 1'b0);
        inc_pulse();
        tick_q.push_back(hms(9, 9, 10));
        run_n(8);
        snap(hms(9, 9, 9), 2'b00, 1'b0);
        step();
        snap(hms(9, 9, 10), 2'b00, 1'b1);

        // 6: asynchronous reset in SET_MIN, then in RUN with the prescaler mid-count
        load_pulse(hms(3, 4, 5));
        run_n(4);
        mode_pulse();
        mode_pulse();
        run_n(3);
        rst_n = 1'b0;
        snap(17'h0, 2'b00, 1'b0);
        step();
        snap(17'h0, 2'b00, 1'b0);
        rst_n = 1'b1;
        run_n(5);
        rst_n = 1'b0;
        snap(17'h0, 2'b00, 1'b0);
        step();
        rst_n = 1'b1;
        tick_q.push_back(17'h00001);
        run_n(9);
        snap(17'h00000, 2'b00, 1'b0);
        step();
        snap(17'h00001, 2'b00, 1'b1);
        run_n(2);

        @(negedge clk);
        #1;
        checks++;
        if (tick_q.size() != 0) begin
            errors++;
            $display("FAIL missed_ticks got=%0d pending exp=0", tick_q.size());
        end
        checks++;
        if (snap_q.size() != 0) begin
            errors++;
            $display("FAIL unchecked_snapshots got=%0d pending exp=0", snap_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
